// File: rtl/helios_sched_pkg.sv
// Shared types and helpers for the Helios decode round scheduler and its syndrome FIFO.
package helios_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    localparam int CYCLE_COUNT_WIDTH = 32;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/syndrome_fifo.sv
// Small syndrome buffer between the host stream and the round scheduler.
// Power-of-two depth; pointers wrap naturally, occupancy is a registered count.
module syndrome_fifo
    import helios_sched_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/decode_round_scheduler.sv
// Sequences buffered syndrome rounds into the Helios decoder and returns captured results.
// Optional watchdog in WAIT is enabled with the HELIOS_WATCHDOG_EN macro.
//
// state | meaning
// IDLE  | waiting for a buffered round and no unacknowledged result
// LOAD  | latch FIFO head onto dec_measurements, pop it
// START | one-cycle new_round_start pulse, clear guard/watchdog
// WAIT  | wait out the guard window, then capture result (or time out)
module decode_round_scheduler
    import helios_sched_pkg::*;
#(
    parameter int PU_COUNT         = 18,
    parameter int CORRECTION_COUNT = 33,
    parameter int FIFO_DEPTH       = 4,
    parameter int GUARD_CYCLES     = 2
`ifdef HELIOS_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES   = 4096
`endif
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PU_COUNT-1:0]                 in_measurements,
    output logic [PU_COUNT-1:0]                 dec_measurements,
    output logic                                dec_new_round_start,
    input  logic                                dec_result_valid,
    input  logic [CORRECTION_COUNT-1:0]         dec_correction,
    input  logic [CYCLE_COUNT_WIDTH-1:0]        dec_cycle_counter,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CORRECTION_COUNT-1:0]         out_correction,
    output logic [CYCLE_COUNT_WIDTH-1:0]        out_cycles,
    output logic                                out_timeout,
    output logic [occ_width(FIFO_DEPTH)-1:0]    fifo_count
);

    localparam int GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(GUARD_CYCLES);

    sched_state_t                   state_q, state_d;
    logic [PU_COUNT-1:0]            dec_meas_q, dec_meas_d;
    logic [GUARD_W-1:0]             guard_q, guard_d;
    logic                           out_valid_q, out_valid_d;
    logic [CORRECTION_COUNT-1:0]    out_corr_q, out_corr_d;
    logic [CYCLE_COUNT_WIDTH-1:0]   out_cyc_q, out_cyc_d;

    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [PU_COUNT-1:0]            fifo_head;
    logic                           capture;
    logic                           timeout;
    logic [CYCLE_COUNT_WIDTH-1:0]   timeout_value;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    syndrome_fifo #(
        .WIDTH (PU_COUNT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_measurements),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The guard window hides the result_valid still asserted from the previous round.
    assign capture = (state_q == WAIT) && (guard_q == GUARD_MAX) && dec_result_valid;

`ifdef HELIOS_WATCHDOG_EN
    logic [CYCLE_COUNT_WIDTH-1:0] wdog_q, wdog_d;
    logic                         out_timeout_q, out_timeout_d;

    assign timeout_value = CYCLE_COUNT_WIDTH'(TIMEOUT_CYCLES);
    assign timeout       = (state_q == WAIT) && (wdog_q == timeout_value - CYCLE_COUNT_WIDTH'(1));
    assign out_timeout   = out_timeout_q;

    always_comb begin
        wdog_d        = wdog_q;
        out_timeout_d = out_timeout_q;
        if (state_q == START) begin
            wdog_d = '0;
        end else if (state_q == WAIT) begin
            wdog_d = wdog_q + CYCLE_COUNT_WIDTH'(1);
        end
        if (capture) begin
            out_timeout_d = 1'b0;
        end else if (timeout) begin
            out_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q        <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            out_timeout_q <= out_timeout_d;
        end
    end
`else
    assign timeout_value = '0;
    assign timeout       = 1'b0;
    assign out_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && !out_valid_q) state_d = LOAD;
            LOAD:    state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (capture || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dec_meas_d          = dec_meas_q;
        guard_d             = guard_q;
        out_valid_d         = out_valid_q;
        out_corr_d          = out_corr_q;
        out_cyc_d           = out_cyc_q;
        dec_new_round_start = 1'b0;
        fifo_pop            = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            LOAD: begin
                dec_meas_d = fifo_head;
                fifo_pop   = 1'b1;
            end
            START: begin
                dec_new_round_start = 1'b1;
                guard_d             = '0;
            end
            WAIT: begin
                if (guard_q != GUARD_MAX) begin
                    guard_d = guard_q + GUARD_W'(1);
                end
                // A real result wins over a watchdog expiry in the same cycle.
                if (capture) begin
                    out_corr_d  = dec_correction;
                    out_cyc_d   = dec_cycle_counter;
                    out_valid_d = 1'b1;
                end else if (timeout) begin
                    out_corr_d  = '0;
                    out_cyc_d   = timeout_value;
                    out_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_meas_q  <= '0;
            guard_q     <= '0;
            out_valid_q <= 1'b0;
            out_corr_q  <= '0;
            out_cyc_q   <= '0;
        end else begin
            dec_meas_q  <= dec_meas_d;
            guard_q     <= guard_d;
            out_valid_q <= out_valid_d;
            out_corr_q  <= out_corr_d;
            out_cyc_q   <= out_cyc_d;
        end
    end

    assign dec_measurements = dec_meas_q;
    assign out_valid        = out_valid_q;
    assign out_correction   = out_corr_q;
    assign out_cycles       = out_cyc_q;

endmodule

// File: tb/tb_decode_round_scheduler.sv
// Directed, scoreboard-based bench for decode_round_scheduler with a small decoder stub.
module tb_decode_round_scheduler;
    import helios_sched_pkg::*;

    localparam int PU = 18;
    localparam int CC = 33;
    localparam int CW = occ_width(4);

    typedef struct packed {
        logic [CC-1:0] corr;
        logic [31:0]   cyc;
        logic          tmo;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          in_valid;
    logic          in_ready;
    logic [PU-1:0] in_measurements;
    logic [PU-1:0] dec_measurements;
    logic          dec_new_round_start;
    logic          dec_result_valid;
    logic [CC-1:0] dec_correction;
    logic [31:0]   dec_cycle_counter;
    logic          out_valid;
    logic          out_ready;
    logic [CC-1:0] out_correction;
    logic [31:0]   out_cycles;
    logic          out_timeout;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    decode_round_scheduler #(
        .PU_COUNT         (PU),
        .CORRECTION_COUNT (CC),
        .FIFO_DEPTH       (4),
        .GUARD_CYCLES     (2)
`ifdef HELIOS_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES   (16)
`endif
    ) dut (
        .clk                 (clk),
        .reset               (rst_b),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_measurements     (in_measurements),
        .dec_measurements    (dec_measurements),
        .dec_new_round_start (dec_new_round_start),
        .dec_result_valid    (dec_result_valid),
        .dec_correction      (dec_correction),
        .dec_cycle_counter   (dec_cycle_counter),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_correction      (out_correction),
        .out_cycles          (out_cycles),
        .out_timeout         (out_timeout),
        .fifo_count          (fifo_count)
    );

    function automatic logic [CC-1:0] m_corr(input logic [PU-1:0] m);
        return {15'h0, m} ^ 33'h1_5555_0000;
    endfunction

    function automatic logic [31:0] m_cyc(input logic [PU-1:0] m);
        return {14'h0, m} + 32'd100;
    endfunction

    // Decoder stub: result_valid stays high until the next start pulse (unless stale mode keeps it).
    int          stub_delay = 10;
    bit          stub_never = 0;
    bit          stub_stale = 0;
    bit          stub_fixed = 0;
    logic [CC-1:0] fix_corr = '0;
    logic [31:0] fix_cyc = '0;
    int          stub_cnt;
    bit          stub_run;
    int          pulses = 0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dec_result_valid  <= 1'b0;
            dec_correction    <= '0;
            dec_cycle_counter <= '0;
            stub_cnt          <= 0;
            stub_run          <= 1'b0;
        end else if (dec_new_round_start) begin
            pulses   <= pulses + 1;
            stub_run <= !stub_never;
            stub_cnt <= stub_delay;
            if (!stub_stale) dec_result_valid <= 1'b0;
        end else if (stub_run) begin
            if (stub_cnt <= 1) begin
                stub_run          <= 1'b0;
                dec_result_valid  <= 1'b1;
                dec_correction    <= stub_fixed ? fix_corr : m_corr(dec_measurements);
                dec_cycle_counter <= stub_fixed ? fix_cyc : m_cyc(dec_measurements);
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [PU-1:0] m);
        res_t e;
        e.corr = m_corr(m);
        e.cyc  = m_cyc(m);
        e.tmo  = 1'b0;
        sb.push_back(e);
    endtask

    // All tasks start and end at a negedge.
    task automatic push_word(input logic [PU-1:0] w, output bit acc);
        in_valid        = 1'b1;
        in_measurements = w;
        acc             = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (dec_new_round_start) seen = 1;
            else @(negedge clk);
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        chk(tag, seen, 1);
    endtask

    // Compare the pending result, acknowledge it, and optionally push a word in the following LOAD cycle.
    task automatic get_result(input string tag, input bit do_push, input logic [PU-1:0] w);
        res_t e = '0;
        bit   acc;
        int   cbefore;
        wait_valid({tag, "_valid"});
        chk({tag, "_sb_has_entry"}, sb.size() > 0, 1);
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_corr"}, out_correction, e.corr);
        chk({tag, "_cycles"}, out_cycles, e.cyc);
        chk({tag, "_timeout"}, out_timeout, e.tmo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_cleared"}, out_valid, 0);
        if (do_push) begin
            @(negedge clk);
            cbefore         = fifo_count;
            in_valid        = 1'b1;
            in_measurements = w;
            acc             = in_ready;
            if (acc) exp_push(w);
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, "_pushpop_acc"}, acc, 1);
            chk({tag, "_pushpop_pulse"}, dec_new_round_start, 1);
            chk({tag, "_pushpop_count"}, fifo_count, cbefore);
        end
    endtask

    initial begin : main
        bit            acc;
        int            p0;
        bit            saw_valid;
        bit            saw_pulse;
        res_t          t;
        logic [PU-1:0] wl [4];
        wl[0] = 18'h11111;
        wl[1] = 18'h22222;
        wl[2] = 18'h33333;
        wl[3] = 18'h04444;

        in_valid        = 1'b0;
        in_measurements = '0;
        out_ready       = 1'b0;
        rst_b           = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dec_meas", dec_measurements, 0);
        chk("rst_start", dec_new_round_start, 0);
        chk("rst_out_corr", out_correction, 0);
        chk("rst_out_cycles", out_cycles, 0);
        chk("rst_out_timeout", out_timeout, 0);
        rst_b = 1'b1;
        @(negedge clk);

        // Single round with fixed stub result.
        stub_fixed = 1;
        fix_corr   = 33'h1_0000_0003;
        fix_cyc    = 32'd7;
        stub_delay = 10;
        push_word(18'h2A5A5, acc);
        chk("t1_accept", acc, 1);
        t.corr = 33'h1_0000_0003;
        t.cyc  = 32'd7;
        t.tmo  = 1'b0;
        sb.push_back(t);
        wait_pulse("t1_pulse");
        chk("t1_meas_at_pulse", dec_measurements, 18'h2A5A5);
        wait_valid("t1_wait");
        chk("t1_meas_at_result", dec_measurements, 18'h2A5A5);
        get_result("t1", 0, '0);
        chk("t1_pulse_count", pulses, 1);
        stub_fixed = 0;

        // Fill with a result pending, refuse the fifth word, then drain with push/pop in LOAD.
        push_word(18'h0A0A0, acc);
        if (acc) exp_push(18'h0A0A0);
        wait_valid("t2_a_pending");
        for (int i = 0; i < 4; i++) begin
            push_word(wl[i], acc);
            if (acc) exp_push(wl[i]);
            chk("t2_fill_accept", acc, 1);
        end
        push_word(18'h3FFFF, acc);
        if (acc) exp_push(18'h3FFFF);
        chk("t2_fifth_refused", acc, 0);
        chk("t2_in_ready_low", in_ready, 0);
        chk("t2_count_full", fifo_count, 4);
        p0 = pulses;
        repeat (8) @(negedge clk);
        chk("t2_no_pulse_while_pending", pulses, p0);
        chk("t2_count_held", fifo_count, 4);
        get_result("t2_a", 0, '0);
        get_result("r1", 1, 18'h15555);
        get_result("r2", 1, 18'h26666);
        get_result("r3", 0, '0);
        get_result("r4", 0, '0);
        get_result("r5", 0, '0);
        get_result("r6", 0, '0);
        chk("t4_pulse_count", pulses, p0 + 6);
        chk("t4_count_empty", fifo_count, 0);

        // Stale result_valid held high across the guard window.
        stub_stale = 1;
        stub_delay = 2;
        push_word(18'h01234, acc);
        if (acc) exp_push(18'h01234);
        get_result("t3_s1", 0, '0);
        push_word(18'h02BCD, acc);
        if (acc) exp_push(18'h02BCD);
        get_result("t3_s2", 0, '0);
        repeat (10) @(negedge clk);
        chk("t3_no_extra_result", out_valid, 0);
        stub_stale = 0;
        stub_delay = 10;

        // Reset in the middle of WAIT with two words buffered.
        stub_never = 1;
        push_word(18'h00AAA, acc);
        wait_pulse("t5_pulse");
        push_word(18'h00BBB, acc);
        push_word(18'h00CCC, acc);
        repeat (4) @(negedge clk);
        chk("t5_count_before", fifo_count, 2);
        rst_b = 1'b0;
        @(negedge clk);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_dec_meas", dec_measurements, 0);
        chk("t5_rst_out_corr", out_correction, 0);
        chk("t5_rst_out_cycles", out_cycles, 0);
        chk("t5_rst_in_ready", in_ready, 1);
        rst_b     = 1'b1;
        saw_valid = 0;
        saw_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            saw_valid |= out_valid;
            saw_pulse |= dec_new_round_start;
        end
        chk("t5_no_valid_after", saw_valid, 0);
        chk("t5_no_pulse_after", saw_pulse, 0);
        chk("t5_count_after", fifo_count, 0);

`ifdef HELIOS_WATCHDOG_EN
        // Watchdog expiry, then the next buffered round completes normally.
        stub_never = 1;
        push_word(18'h0DEAD, acc);
        t.corr = '0;
        t.cyc  = 32'd16;
        t.tmo  = 1'b1;
        if (acc) sb.push_back(t);
        push_word(18'h0BEEF, acc);
        if (acc) exp_push(18'h0BEEF);
        wait_pulse("t6_pulse");
        @(negedge clk);
        stub_never = 0;
        get_result("t6_timeout", 0, '0);
        get_result("t6_next", 0, '0);
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
